// File: rtl/mdu_if.sv
// mdu_if: E-stage <-> multiply/divide unit bundle.
// master = pipeline side, slave = mdu_ctrl side.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    output mf_req, flush,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  mf_req, flush,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MULT/DIV sequencer and HI/LO owner.
// Define MDU_DIV_EN to build the divider (DIV/SIGN states).
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef MDU_DIV_EN
    , S_DIV,
    S_SIGN
`endif
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sgn;

  logic        w_accept;
  logic        w_op_mul;
  logic        w_op_mthi;
  logic        w_op_mtlo;
  logic [63:0] w_pa;
  logic [63:0] w_pb;
  logic [63:0] w_prod;

  assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.flush;
  assign w_op_mul  = (bus.op[2:1] == 2'b00);
  assign w_op_mthi = (bus.op == 3'b100);
  assign w_op_mtlo = (bus.op == 3'b101);

  // Sign-extend for MULT; low 64 bits of the product are then exact
  assign w_pa   = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_pb   = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod = w_pa * w_pb;

`ifdef MDU_DIV_EN
  logic [31:0] r_q;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [31:0] r_rsv;
  logic        r_sa;
  logic        r_sb;
  logic        r_dz;

  logic        w_op_div;
  logic        w_sa;
  logic        w_sb;
  logic [32:0] w_rsh;
  logic [32:0] w_dif;

  assign w_op_div = (bus.op[2:1] == 2'b01);
  assign w_sa     = ~bus.op[0] & bus.rs_val[31];
  assign w_sb     = ~bus.op[0] & bus.rt_val[31];
  // One restoring step: shift next dividend bit in, try subtract
  assign w_rsh    = {r_rem, r_q[31]};
  assign w_dif    = w_rsh - {1'b0, r_dvs};
`endif

  assign bus.busy  = r_busy;
  assign bus.stall = r_busy & (bus.start | bus.mf_req);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  // Sequencer FSM with HI/LO and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sgn   <= 1'b0;
`ifdef MDU_DIV_EN
      r_q     <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_rsv   <= 32'd0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (1'b1)
              w_op_mul: begin
                r_a     <= bus.rs_val;
                r_b     <= bus.rt_val;
                r_sgn   <= ~bus.op[0];
                r_cnt   <= 5'(MUL_CYCLES - 1);
                r_state <= S_MUL;
                r_busy  <= 1'b1;
              end
`ifdef MDU_DIV_EN
              w_op_div: begin
                r_q     <= w_sa ? -bus.rs_val : bus.rs_val;
                r_dvs   <= w_sb ? -bus.rt_val : bus.rt_val;
                r_rem   <= 32'd0;
                r_rsv   <= bus.rs_val;
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_dz    <= (bus.rt_val == 32'd0);
                r_cnt   <= 5'd31;
                r_state <= S_DIV;
                r_busy  <= 1'b1;
              end
`endif
              w_op_mthi: r_hi <= bus.rs_val;
              w_op_mtlo: r_lo <= bus.rs_val;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 5'd0) begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
`ifdef MDU_DIV_EN
        S_DIV: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_dif[32] ? w_rsh[31:0] : w_dif[31:0];
            r_q   <= {r_q[30:0], ~w_dif[32]};
            if (r_cnt == 5'd0) r_state <= S_SIGN;
            else r_cnt <= r_cnt - 5'd1;
          end
        end
        S_SIGN: begin
          if (!bus.flush) begin
            if (r_dz) begin
              r_lo <= 32'hFFFF_FFFF;
              r_hi <= r_rsv;
            end else begin
              r_lo <= (r_sa ^ r_sb) ? -r_q : r_q;
              r_hi <= r_sa ? -r_rem : r_rem;
            end
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl.
// DIV expectations follow the MDU_DIV_EN build setting.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   nb;

  mdu_if u_if ();

  mdu_ctrl #(.MUL_CYCLES(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one op from IDLE, return number of busy cycles seen
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cnt);
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.rs_val = a;
    u_if.rt_val = b;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    cnt = 0;
    while (u_if.busy && cnt < 100) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  initial begin
    u_if.start  = 1'b0;
    u_if.op     = 3'b111;
    u_if.rs_val = 32'd0;
    u_if.rt_val = 32'd0;
    u_if.mf_req = 1'b0;
    u_if.flush  = 1'b0;
    do_rst();

    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_stall", {31'd0, u_if.stall}, 32'd0);
    chk("rst_hi", u_if.hi, 32'd0);
    chk("rst_lo", u_if.lo, 32'd0);

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, nb);
    chk("mult_cyc", nb, 32'd5);
    chk("mult_hi", u_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", u_if.lo, 32'hFFFF_FFFA);

    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, nb);
    chk("multu_cyc", nb, 32'd5);
    chk("multu_hi", u_if.hi, 32'h0000_0002);
    chk("multu_lo", u_if.lo, 32'hFFFF_FFFA);

`ifdef MDU_DIV_EN
    run_op(3'b010, -32'sd7, 32'd2, nb);
    chk("div_cyc", nb, 32'd33);
    chk("div_lo", u_if.lo, 32'hFFFF_FFFD);
    chk("div_hi", u_if.hi, 32'hFFFF_FFFF);

    run_op(3'b011, 32'd100, 32'd7, nb);
    chk("divu_cyc", nb, 32'd33);
    chk("divu_lo", u_if.lo, 32'd14);
    chk("divu_hi", u_if.hi, 32'd2);

    run_op(3'b011, 32'h1234_5678, 32'd0, nb);
    chk("dz_cyc", nb, 32'd33);
    chk("dz_lo", u_if.lo, 32'hFFFF_FFFF);
    chk("dz_hi", u_if.hi, 32'h1234_5678);
`else
    run_op(3'b010, 32'd10, 32'd3, nb);
    chk("nodiv_cyc", nb, 32'd0);
    chk("nodiv_hi", u_if.hi, 32'h0000_0002);
    chk("nodiv_lo", u_if.lo, 32'hFFFF_FFFA);
`endif

    run_op(3'b000, 32'd6, 32'd7, nb);
    chk("m67_lo", u_if.lo, 32'd42);
    chk("m67_hi", u_if.hi, 32'd0);

    // MFHI/MFLO behind a MULT
    u_if.start  = 1'b1;
    u_if.op     = 3'b000;
    u_if.rs_val = 32'd3;
    u_if.rt_val = 32'd5;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    u_if.mf_req = 1'b1;
    nb = 0;
    while (u_if.stall && nb < 100) begin
      @(posedge clk);
      #1 nb++;
    end
    chk("mf_stall", nb, 32'd5);
    chk("mf_lo", u_if.lo, 32'd15);
    chk("mf_busy", {31'd0, u_if.busy}, 32'd0);
    u_if.mf_req = 1'b0;

    // MTLO / MTHI in IDLE
    u_if.start  = 1'b1;
    u_if.op     = 3'b101;
    u_if.rs_val = 32'd5;
    #1 chk("mtlo_stall", {31'd0, u_if.stall}, 32'd0);
    @(posedge clk);
    #1 u_if.start = 1'b0;
    chk("mtlo_lo", u_if.lo, 32'd5);
    chk("mtlo_busy", {31'd0, u_if.busy}, 32'd0);
    run_op(3'b100, 32'hCAFE_0001, 32'd0, nb);
    chk("mthi_hi", u_if.hi, 32'hCAFE_0001);
    chk("mthi_lo", u_if.lo, 32'd5);

    // Reserved op ignored
    run_op(3'b110, 32'hDEAD_BEEF, 32'd1, nb);
    chk("nop_cyc", nb, 32'd0);
    chk("nop_hi", u_if.hi, 32'hCAFE_0001);

    // Back-to-back: second op held until busy drops
    u_if.start  = 1'b1;
    u_if.op     = 3'b000;
    u_if.rs_val = 32'd2;
    u_if.rt_val = 32'd3;
    @(posedge clk);
    #1 u_if.op  = 3'b001;
    u_if.rs_val = 32'd4;
    u_if.rt_val = 32'd5;
    nb = 0;
    while (u_if.stall && nb < 100) begin
      @(posedge clk);
      #1 nb++;
    end
    chk("b2b_stall", nb, 32'd5);
    chk("b2b_lo1", u_if.lo, 32'd6);
    @(posedge clk);
    #1 u_if.start = 1'b0;
    chk("b2b_busy2", {31'd0, u_if.busy}, 32'd1);
    nb = 0;
    while (u_if.busy && nb < 100) begin
      @(posedge clk);
      #1 nb++;
    end
    chk("b2b_cyc2", nb, 32'd5);
    chk("b2b_lo2", u_if.lo, 32'd20);

    // Flush in third busy cycle of a MULT
    do_rst();
    u_if.start  = 1'b1;
    u_if.op     = 3'b000;
    u_if.rs_val = 32'd7;
    u_if.rt_val = 32'd9;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 u_if.flush = 1'b1;
    @(posedge clk);
    #1 u_if.flush = 1'b0;
    chk("fl_busy", {31'd0, u_if.busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1 chk("fl_hi", u_if.hi, 32'd0);
    chk("fl_lo", u_if.lo, 32'd0);

    // Flush with start in IDLE blocks accept
    u_if.start  = 1'b1;
    u_if.flush  = 1'b1;
    u_if.op     = 3'b101;
    u_if.rs_val = 32'd9;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    u_if.flush = 1'b0;
    chk("flst_lo", u_if.lo, 32'd0);

    // Reset in the middle of a long op
    run_op(3'b100, 32'd77, 32'd0, nb);
    u_if.start  = 1'b1;
`ifdef MDU_DIV_EN
    u_if.op     = 3'b010;
`else
    u_if.op     = 3'b000;
`endif
    u_if.rs_val = 32'd100;
    u_if.rt_val = 32'd7;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    chk("mid_busy", {31'd0, u_if.busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("mrst_hi", u_if.hi, 32'd0);
    chk("mrst_lo", u_if.lo, 32'd0);
    repeat (40) @(posedge clk);
    #1 chk("mrst_hi2", u_if.hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
